// File: rtl/ntt_loop_ctrl.sv
// NTT/INTT/PWM loop sequencer: walks stage i and group s for addr_gen.
// Optional LOOP_CTRL_PERF_EN adds a cycle_cnt busy-cycle counter output.
module ntt_loop_ctrl #(
  parameter int P_SHIFT    = 2,
  parameter int NUM_STAGES = 7,
  parameter int STAGE_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] opcode,
  input  logic       stall,
  output logic [5:0] i,
  output logic [6:0] s,
  output logic [1:0] opcode_o,
  output logic       valid,
  output logic       last,
  output logic       busy,
  output logic       done
`ifdef LOOP_CTRL_PERF_EN
  ,
  output logic [15:0] cycle_cnt
`endif
);

  localparam logic [1:0] OP_NTT  = 2'd0;
  localparam logic [1:0] OP_INTT = 2'd1;

  localparam logic [6:0] S_STEP    = 7'(1 << P_SHIFT);
  localparam logic [6:0] S_NTT_MAX = 7'(128 - (1 << P_SHIFT));
  localparam logic [6:0] S_PWM_MAX = 7'((256 >> P_SHIFT) - 1);
  localparam logic [5:0] I_LAST    = 6'(NUM_STAGES - 1);
  localparam logic [3:0] GAP_INIT  =
    4'((STAGE_GAP > 0) ? (STAGE_GAP - 1) : 0);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] gap_cnt;

  logic       is_ntt;
  logic       is_intt;
  logic       is_pwm;
  logic [6:0] s_max;
  logic [6:0] s_inc;
  logic [5:0] i_next;
  logic       stage_end;
  logic       final_stage;
  logic       last_nxt;

  // Any opcode other than NTT/INTT sequences like PWM.
  always_comb begin
    is_ntt  = (opcode_o == OP_NTT);
    is_intt = (opcode_o == OP_INTT);
    is_pwm  = !(is_ntt || is_intt);
    s_max   = is_pwm ? S_PWM_MAX : S_NTT_MAX;
    s_inc   = s + (is_pwm ? 7'd1 : S_STEP);
    i_next  = i;
    if (is_intt) begin
      if (i != 6'd0) i_next = i - 6'd1;
    end else if (is_ntt) begin
      if (i != I_LAST) i_next = i + 6'd1;
    end
    stage_end   = (s == s_max);
    final_stage = is_pwm ||
                  (is_intt && (i == 6'd0)) ||
                  (is_ntt && (i == I_LAST));
    last_nxt    = final_stage && (s_inc == s_max);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      i        <= '0;
      s        <= '0;
      opcode_o <= '0;
      valid    <= 1'b0;
      last     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            opcode_o <= opcode;
            i        <= (opcode == OP_INTT) ? I_LAST : 6'd0;
            s        <= '0;
            valid    <= 1'b1;
            last     <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (!stall) begin
            if (last) begin
              state <= DONE;
              valid <= 1'b0;
              last  <= 1'b0;
              done  <= 1'b1;
            end else if (stage_end) begin
              if (STAGE_GAP > 0) begin
                state   <= GAP;
                valid   <= 1'b0;
                gap_cnt <= GAP_INIT;
              end else begin
                i <= i_next;
                s <= '0;
              end
            end else begin
              s    <= s_inc;
              last <= last_nxt;
            end
          end
        end
        GAP: begin
          if (!stall) begin
            if (gap_cnt == 4'd0) begin
              state <= RUN;
              valid <= 1'b1;
              i     <= i_next;
              s     <= '0;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end
        end
        DONE: begin
          if (!stall) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOOP_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (state == IDLE && start) begin
      cycle_cnt <= '0;
    end else if (busy) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/ntt_loop_ctrl.md
Name: ntt_loop_ctrl

Overview:
- Loop sequencer directly upstream of the address generator in each lane.
- On a start pulse it walks the stage index i and butterfly/group index s for one full NTT, INTT or PWM pass over a 256-coefficient polynomial.
- Presents registered {i, s, opcode} with a valid strobe to addr_gen every cycle.
- Inserts a programmable bubble between NTT/INTT stages so butterfly write-back completes before the next stage reads.

Parameters:
- P_SHIFT, 2, log2 of coefficients touched per cycle; must equal the codebase `P_SHIFT (legal 1..5).
- NUM_STAGES, 7, number of NTT/INTT stages.
- STAGE_GAP, 4, idle cycles between consecutive NTT/INTT stages (0 legal, max 15).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, single-cycle request; sampled only in IDLE.
- opcode, input, 2, operation (`NTT, `INTT, `PWM0, `PWM1 from parameter.v); latched on accepted start.
- stall, input, 1, freezes all counters and outputs while high.
- i, output, 6, stage index to addr_gen.
- s, output, 7, group/butterfly index to addr_gen.
- opcode_o, output, 2, latched opcode.
- valid, output, 1, i/s are a live beat this cycle.
- last, output, 1, final beat of the pass (qualified by valid).
- busy, output, 1, high from the cycle after start accepted through the done cycle.
- done, output, 1, one-cycle pulse after the final beat.

Behaviour:
- Reset: state IDLE; i=0, s=0, opcode_o=0, valid=0, last=0, busy=0, done=0. Reset mid-pass aborts immediately with no done pulse.
- States: IDLE, RUN, GAP, DONE. All outputs registered.
- IDLE:
  - start=1 latches opcode; next cycle is RUN with the first beat (valid=1).
  - Start-to-first-beat latency is 1 cycle.
- NTT beat order: i counts 0..NUM_STAGES-1. Within each stage, s counts 0, 2^P_SHIFT, 2·2^P_SHIFT ... 128-2^P_SHIFT (128>>P_SHIFT beats/stage). Low P_SHIFT bits of s are always 0.
- INTT beat order: same s sequence, but i counts NUM_STAGES-1 down to 0.
- PWM0/PWM1 beat order: i held 0; s counts 0..(256>>P_SHIFT)-1 by 1; single pass with no GAP.
- RUN → GAP: after the last s of a non-final stage, when STAGE_GAP>0. GAP holds valid=0 for exactly STAGE_GAP cycles, then returns to RUN with s=0 and i advanced.
- STAGE_GAP=0: next stage's first beat follows back-to-back.
- RUN → DONE: after the beat flagged last. DONE drives done=1 and busy=1 for one cycle, valid=0, then goes to IDLE.
- last=1 only on the final beat: NTT i=NUM_STAGES-1; INTT i=0; with s at its max value.
- stall=1 in RUN/GAP/DONE holds state, counters and all outputs unchanged (valid stays as is; no beat is consumed). In IDLE, stall is ignored.
- start while busy is ignored; its opcode is not latched.
- Width/arithmetic rules:
  - s increment is 7-bit and never wraps mid-stage; the terminal compare is on the exact max value.
  - i decrement in INTT stops at 0 and never underflows.
- Undefined opcode values are treated as PWM0 sequencing.

Optional Feature:
- Macro: LOOP_CTRL_PERF_EN.
- Defined: adds output cycle_cnt [15:0]. It clears on accepted start, increments every cycle while busy (including stall and GAP cycles), holds its value after done until the next start, and resets to 0.
- Undefined: port absent; no counter logic.

Test Plan:
- NTT, P_SHIFT=2, STAGE_GAP=4, start at T: first beat at T+1 with i=0, s=0.
  - Expect 7×32=224 valid beats and 6 gaps of 4 cycles.
  - last on beat i=6, s=124; done at T+249; busy low at T+250.
- INTT, same parameters: i sequence 6,5,...,0; first beat i=6, s=0; last beat i=0, s=124.
- PWM1, P_SHIFT=2: 64 consecutive beats with i=0, s=0..63, no gaps; done at T+65.
- stall held 3 cycles in the middle of stage 2 and again during a GAP: outputs frozen. Total pass lengthens by exactly 6 cycles; beat sequence unchanged.
- start re-asserted with a different opcode mid-pass: ignored, opcode_o unchanged.
- rst asserted at beat 100: next cycle all outputs 0 and state IDLE, no done pulse. A fresh start then runs a full pass.
- With LOOP_CTRL_PERF_EN, NTT case above: cycle_cnt=249 after done; it holds 249 until the next start.
